// File: rtl/gba_bus_master_pkg.sv
// Shared FSM encoding, default bus timing and timer sizing for the GBA cartridge-bus initiator.
package gba_bus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HOLD,
    S_TURN,
    S_WAITD,
    S_STROBE,
    S_RECOVER,
    S_FIN
  } state_t;

  localparam int unsigned DEF_ADDR_SETUP     = 2;
  localparam int unsigned DEF_ADDR_HOLD      = 4;
  localparam int unsigned DEF_STROBE_CYCLES  = 8;
  localparam int unsigned DEF_RECOVER_CYCLES = 4;
  localparam int unsigned DEF_LEN_W          = 8;

  // Counter width that holds (largest phase length - 1); never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gba_bus_master_phase_timer.sv
// Loadable down-counter timing each bus phase; done_o is high while the count sits at zero.
// Loading N-1 on phase entry makes the phase last N cycles; no backpressure.
module gba_bus_master_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gba_bus_master.sv
// GBA cartridge-bus initiator: address-latch phase then RD/WR strobe bursts of 1..2^LEN_W beats.
// All bus pins registered; commands wait on cmd_ready_o (IDLE only), write beats stall on wdata_valid_i.
module gba_bus_master
  import gba_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_SETUP     = DEF_ADDR_SETUP,
  parameter int unsigned ADDR_HOLD      = DEF_ADDR_HOLD,
  parameter int unsigned STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int unsigned LEN_W          = DEF_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [15:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [15:0]      wdata_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  output logic [15:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             busy_o,
  output logic             cs_o,
  output logic             rd_o,
  output logic             wr_o,
  output logic [15:0]      ad_out_o,
  output logic             ad_oe_o,
  input  logic [15:0]      ad_in_i
);

  if (ADDR_SETUP == 0 || ADDR_HOLD == 0 || STROBE_CYCLES == 0 || RECOVER_CYCLES == 0)
  begin : g_bad_timing
    $error("gba_bus_master: timing parameters must be nonzero");
  end

  localparam int unsigned TW = timer_width(ADDR_SETUP, ADDR_HOLD, STROBE_CYCLES, RECOVER_CYCLES);
  localparam logic [TW-1:0] LD_SETUP   = TW'(ADDR_SETUP - 1);
  localparam logic [TW-1:0] LD_HOLD    = TW'(ADDR_HOLD - 1);
  localparam logic [TW-1:0] LD_STROBE  = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] LD_RECOVER = TW'(RECOVER_CYCLES - 1);

  state_t            state_q, state_d;
  logic              write_q;
  logic [LEN_W:0]    beats_q;
  logic [15:0]       ad_out_q, rdata_q;
  logic              rdata_valid_q, wdata_ready_q;
  logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_val;
  logic              accept, strobe_entry, strobe_last;

  gba_bus_master_phase_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_valid_i) state_d = S_SETUP;
      S_SETUP:   if (tmr_done) state_d = S_HOLD;
      S_HOLD:    if (tmr_done) state_d = S_TURN;
      S_TURN:    state_d = (write_q && !wdata_valid_i) ? S_WAITD : S_STROBE;
      S_WAITD:   if (wdata_valid_i) state_d = S_STROBE;
      S_STROBE:  if (tmr_done) state_d = S_RECOVER;
      S_RECOVER: if (tmr_done) state_d = (beats_q == '0) ? S_FIN : (write_q ? S_TURN : S_STROBE);
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Every phase change reloads the timer with the new phase's length.
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      S_SETUP:   tmr_val = LD_SETUP;
      S_HOLD:    tmr_val = LD_HOLD;
      S_STROBE:  tmr_val = LD_STROBE;
      S_RECOVER: tmr_val = LD_RECOVER;
      default:   tmr_val = '0;
    endcase

    cs_d = !(state_d inside {S_HOLD, S_TURN, S_WAITD, S_STROBE, S_RECOVER});
    rd_d = !((state_d == S_STROBE) && !write_q);
    wr_d = !((state_d == S_STROBE) && write_q);
    oe_d = (state_d inside {S_SETUP, S_HOLD}) ||
           (write_q && (state_d inside {S_TURN, S_WAITD, S_STROBE, S_RECOVER}));
  end

  assign accept       = (state_q == S_IDLE) && cmd_valid_i;
  assign strobe_entry = (state_d == S_STROBE) && (state_q != S_STROBE);
  assign strobe_last  = (state_q == S_STROBE) && tmr_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      beats_q       <= '0;
      ad_out_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wdata_ready_q <= 1'b0;
      cs_q          <= 1'b1;
      rd_q          <= 1'b1;
      wr_q          <= 1'b1;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      oe_q          <= oe_d;
      rdata_valid_q <= 1'b0;
      wdata_ready_q <= write_q && strobe_entry;
      if (accept) begin
        write_q  <= cmd_write_i;
        beats_q  <= {1'b0, cmd_len_i} + (LEN_W + 1)'(1);
        ad_out_q <= cmd_addr_i;
      end
      if (write_q && strobe_entry) ad_out_q <= wdata_i;
      if (state_d == S_FIN) ad_out_q <= '0;
      if (strobe_last) begin
        beats_q <= beats_q - (LEN_W + 1)'(1);
        if (!write_q) begin
          rdata_q       <= ad_in_i;
          rdata_valid_q <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign cs_o          = cs_q;
  assign rd_o          = rd_q;
  assign wr_o          = wr_q;
  assign ad_oe_o       = oe_q;
  assign ad_out_o      = ad_out_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign wdata_ready_o = wdata_ready_q;

endmodule

// File: tb/tb_gba_bus_master.sv
// Bench: gba_bus_master against a behavioural cartridge responder with 3-stage strobe synchronisers.
module tb_gba_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] wdata = '0;
  logic        wdata_valid = 1'b0, wready;
  logic [15:0] rdata;
  logic        rvalid, busy, cs, rd, wr, oe;
  logic [15:0] ad_out, ad_in;

  always #5 clk = ~clk;

  gba_bus_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wready),
    .rdata_o(rdata), .rdata_valid_o(rvalid), .busy_o(busy),
    .cs_o(cs), .rd_o(rd), .wr_o(wr),
    .ad_out_o(ad_out), .ad_oe_o(oe), .ad_in_i(ad_in)
  );

  // Responder: latches the address on synchronised CS fall, bumps it on every strobe rise.
  logic [2:0]  cs_s, rd_s, wr_s;
  logic [15:0] r_addr, r_reg;
  always @(posedge clk) begin
    if (rst) begin
      cs_s <= '1; rd_s <= '1; wr_s <= '1; r_addr <= '0; r_reg <= '0;
    end else begin
      cs_s <= {cs_s[1:0], cs};
      rd_s <= {rd_s[1:0], rd};
      wr_s <= {wr_s[1:0], wr};
      if (!cs_s[1] && cs_s[2]) r_addr <= ad_out;
      if (rd_s[1] && !rd_s[2]) r_addr <= r_addr + 16'd1;
      if (wr_s[1] && !wr_s[2]) begin
        if (r_addr == 16'h0400) r_reg <= oe ? ad_out : 16'hxxxx;
        r_addr <= r_addr + 16'd1;
      end
    end
  end
  assign ad_in = !rd_s[2] ? (r_addr ^ 16'hA5A5) : 16'hDEAD;

  int n_checks = 0, n_pass = 0;
  logic [15:0] exp_q[$];
  int cs_falls, rd_pulses, wr_pulses, rvalid_cnt, wready_cnt, oe_low_in_cs, min_gap, viol = 0;
  int cs_hi_run = 0;
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;

  // Monitor + scoreboard, sampled on the falling edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs = 1'b1; prev_rd = 1'b1; prev_wr = 1'b1; cs_hi_run = 0;
      end else begin
        if (!rd && oe) viol++;
        if (!rd && !wr) viol++;
        if (busy && cmd_ready) viol++;
        if (!cs && prev_cs) begin
          cs_falls++;
          if (cs_hi_run < min_gap) min_gap = cs_hi_run;
        end
        cs_hi_run = cs ? cs_hi_run + 1 : 0;
        if (!rd && prev_rd) rd_pulses++;
        if (!wr && prev_wr) wr_pulses++;
        if (!cs && !oe) oe_low_in_cs++;
        if (wready) wready_cnt++;
        if (rvalid) begin
          rvalid_cnt++;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_rdata got %h, expected no read beat", rdata);
          end else begin
            e = exp_q.pop_front();
            if (rdata !== e) $display("FAIL sb_rdata got %h expected %h", rdata, e);
            else n_pass++;
          end
        end
        prev_cs = cs; prev_rd = rd; prev_wr = wr;
      end
    end
  end

  task automatic clear_counts();
    cs_falls = 0; rd_pulses = 0; wr_pulses = 0; rvalid_cnt = 0;
    wready_cnt = 0; oe_low_in_cs = 0; min_gap = 1000;
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l, output bit ok);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL cmd_accept addr %h not accepted, expected within 300 cycles", a);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && cmd_ready) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_idle busy=%b, expected return to idle within 3000 cycles", tag, busy);
    end
  endtask

  task automatic wait_wready(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wready === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_wready no pulse, expected within 200 cycles", tag);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s got %0d expected %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cs !== 1'b1)      $display("FAIL reset_cs got %b expected 1", cs); else n_pass++;
    n_checks++; if (rd !== 1'b1)      $display("FAIL reset_rd got %b expected 1", rd); else n_pass++;
    n_checks++; if (wr !== 1'b1)      $display("FAIL reset_wr got %b expected 1", wr); else n_pass++;
    n_checks++; if (oe !== 1'b0)      $display("FAIL reset_oe got %b expected 0", oe); else n_pass++;
    n_checks++; if (ad_out !== 16'h0) $display("FAIL reset_ad_out got %h expected 0000", ad_out); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
    n_checks++; if (rvalid !== 1'b0 || wready !== 1'b0)
      $display("FAIL reset_pulses got rvalid=%b wready=%b expected 0 0", rvalid, wready); else n_pass++;
    n_checks++; if (rdata !== 16'h0)  $display("FAIL reset_rdata got %h expected 0000", rdata); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bit ok;
    clear_counts();
    exp_q.push_back(16'hA5A0);
    send_cmd(1'b0, 16'h0005, 8'd0, ok);
    cmd_valid = 1'b0;
    wait_idle("single_read");
    chk("single_read_rvalid_cnt", rvalid_cnt, 1);
    chk("single_read_rd_pulses", rd_pulses, 1);
    chk("single_read_cs_falls", cs_falls, 1);
    chk("single_read_sb_left", exp_q.size(), 0);
  endtask

  task automatic test_burst_read();
    bit ok;
    clear_counts();
    exp_q.push_back(16'hA65B); exp_q.push_back(16'hA65A);
    exp_q.push_back(16'hA1A5); exp_q.push_back(16'hA1A4);
    send_cmd(1'b0, 16'h03FE, 8'd3, ok);
    cmd_valid = 1'b0;
    wait_idle("burst_read");
    chk("burst_read_rvalid_cnt", rvalid_cnt, 4);
    chk("burst_read_cs_falls", cs_falls, 1);
    chk("burst_read_sb_left", exp_q.size(), 0);
  endtask

  task automatic test_single_write();
    bit ok;
    clear_counts();
    wdata = 16'h03FF; wdata_valid = 1'b1;
    send_cmd(1'b1, 16'h0400, 8'd0, ok);
    cmd_valid = 1'b0;
    wait_wready("single_write");
    wdata_valid = 1'b0;
    wait_idle("single_write");
    chk("single_write_reg", int'(r_reg), 16'h03FF);
    chk("single_write_wr_pulses", wr_pulses, 1);
    chk("single_write_wready_cnt", wready_cnt, 1);
    chk("single_write_oe_drop", oe_low_in_cs, 0);
    chk("single_write_rd_pulses", rd_pulses, 0);
  endtask

  task automatic test_write_stall();
    bit ok;
    int gap_bad = 0;
    bit wr_up = 1'b0;
    clear_counts();
    wdata = 16'h1234; wdata_valid = 1'b1;
    send_cmd(1'b1, 16'h03FF, 8'd1, ok);
    cmd_valid = 1'b0;
    wait_wready("write_stall_b1");
    wdata_valid = 1'b0; wdata = 16'hBEEF;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr === 1'b1) begin wr_up = 1'b1; break; end
    end
    chk("write_stall_wr_release", int'(wr_up), 1);
    repeat (20) begin
      @(negedge clk);
      if (cs !== 1'b0 || wr !== 1'b1) gap_bad++;
    end
    chk("write_stall_gap_bad_cycles", gap_bad, 0);
    wdata_valid = 1'b1;
    wait_wready("write_stall_b2");
    wdata_valid = 1'b0;
    wait_idle("write_stall");
    chk("write_stall_wready_cnt", wready_cnt, 2);
    chk("write_stall_wr_pulses", wr_pulses, 2);
    chk("write_stall_cs_falls", cs_falls, 1);
    chk("write_stall_reg", int'(r_reg), 16'hBEEF);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit hit = 1'b0;
    clear_counts();
    exp_q.push_back(16'h0010 ^ 16'hA5A5);
    send_cmd(1'b0, 16'h0010, 8'd3, ok);
    cmd_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_pulses == 2) begin hit = 1'b1; break; end
    end
    chk("rst_mid_reached_beat2", int'(hit), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobes", int'({cs, rd, wr}), 7);
    chk("rst_mid_oe", int'(oe), 0);
    chk("rst_mid_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_rvalid_cnt", rvalid_cnt, 1);
    chk("rst_mid_wready_cnt", wready_cnt, 0);
    chk("rst_mid_sb_left", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rv_at_accept;
    clear_counts();
    exp_q.push_back(16'h0020 ^ 16'hA5A5);
    exp_q.push_back(16'h0030 ^ 16'hA5A5);
    exp_q.push_back(16'h0031 ^ 16'hA5A5);
    send_cmd(1'b0, 16'h0020, 8'd0, ok);
    send_cmd(1'b0, 16'h0030, 8'd1, ok);
    rv_at_accept = rvalid_cnt;
    cmd_valid = 1'b0;
    wait_idle("back_to_back");
    chk("b2b_first_done_before_accept", rv_at_accept, 1);
    chk("b2b_cs_falls", cs_falls, 2);
    chk("b2b_gap_ok", int'(min_gap >= 3), 1);
    chk("b2b_rvalid_cnt", rvalid_cnt, 3);
    chk("b2b_sb_left", exp_q.size(), 0);
  endtask

  task automatic test_protocol();
    chk("protocol_violations", viol, 0);
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_single_read();
    test_burst_read();
    test_single_write();
    test_write_stall();
    test_reset_mid_burst();
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
